// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// address width and the NOP word.
package instruction_fetch_pkg;

  localparam int ADDR_W = 14;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    REDIRECT = 2'd1,
    HOLD     = 2'd2
  } if_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Program-memory read port used by the fetch stage (master) and the memory (slave).
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues program-memory reads, absorbs wait states,
// stalls and branch redirects, and feeds the IF/ID register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 14'h0000
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic                stall,
  input  logic                take_branch_addr,
  input  logic [ADDR_W-1:0]   branch_addr,
  instruction_fetch_if.master mem,
  output logic [31:0]         instruction_out,
  output logic [ADDR_W-1:0]   return_addr_out
);

  if_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redir_q, redir_d;
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_ret_q, hold_ret_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic              req_en_q;
  logic              req;
  logic              ack;
  logic [ADDR_W-1:0] pc_inc;

  // req_en_q keeps the bus quiet during reset and for the release cycle;
  // an ack without a live request is never acted on.
  assign req    = req_en_q && (state_q != HOLD);
  assign ack    = req && mem.imem_ack;
  assign pc_inc = pc_q + 14'd1;

  assign mem.imem_req    = req;
  assign mem.imem_addr   = pc_q;
  assign instruction_out = instr_q;
  assign return_addr_out = ret_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    hold_instr_d = hold_instr_q;
    hold_ret_d   = hold_ret_q;
    instr_d      = instr_q;
    ret_d        = ret_q;
    if (take_branch_addr) begin
      // Branch wins over stall and ack; any buffered word is dropped.
      instr_d = NOP;
      ret_d   = '0;
      case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = branch_addr;
          end else begin
            redir_d = branch_addr;
            state_d = REDIRECT;
          end
        end
        REDIRECT: begin
          redir_d = branch_addr;
          if (ack) begin
            pc_d    = branch_addr;
            state_d = FETCH;
          end
        end
        HOLD: begin
          pc_d    = branch_addr;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = pc_inc;
            if (stall) begin
              hold_instr_d = mem.imem_rdata;
              hold_ret_d   = pc_inc;
              state_d      = HOLD;
            end else begin
              instr_d = mem.imem_rdata;
              ret_d   = pc_inc;
            end
          end else if (!stall) begin
            instr_d = NOP;
          end
        end
        REDIRECT: begin
          // The in-flight word belongs to the abandoned path.
          if (!stall) instr_d = NOP;
          if (ack) begin
            pc_d    = redir_q;
            state_d = FETCH;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d = hold_instr_q;
            ret_d   = hold_ret_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redir_q      <= '0;
      hold_instr_q <= NOP;
      hold_ret_q   <= '0;
      instr_q      <= NOP;
      ret_q        <= '0;
      req_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_q      <= redir_d;
      hold_instr_q <= hold_instr_d;
      hold_ret_q   <= hold_ret_d;
      instr_q      <= instr_d;
      ret_q        <= ret_d;
      req_en_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: wait-state memory model plus an
// expected-output queue filled as stimulus is applied.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [ADDR_W-1:0] RST_PC = 14'h0000;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] ret;
    logic              chk_ret;
  } exp_t;

  logic              clock = 1'b0;
  logic              nreset = 1'b1;
  logic              stall = 1'b0;
  logic              take_branch_addr = 1'b0;
  logic [ADDR_W-1:0] branch_addr = '0;
  logic [31:0]       instruction_out;
  logic [ADDR_W-1:0] return_addr_out;

  int   checks = 0;
  int   failures = 0;
  int   wait_states = 0;
  int   wcnt;
  exp_t exp_q[$];
  exp_t e;

  instruction_fetch_if mem_bus();

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clock            (clock),
    .nreset           (nreset),
    .stall            (stall),
    .take_branch_addr (take_branch_addr),
    .branch_addr      (branch_addr),
    .mem              (mem_bus),
    .instruction_out  (instruction_out),
    .return_addr_out  (return_addr_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {2'b10, a, 2'b01, a};
  endfunction

  // Memory: ack after wait_states cycles of a held request.
  assign mem_bus.imem_ack   = mem_bus.imem_req && (wcnt == wait_states);
  assign mem_bus.imem_rdata = mem_word(mem_bus.imem_addr);
  always @(posedge clock or negedge nreset) begin
    if (!nreset) wcnt <= 0;
    else if (mem_bus.imem_req && !mem_bus.imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic goto_pc(input logic [ADDR_W-1:0] a);
    take_branch_addr = 1'b1;
    branch_addr = a;
    tick();
    take_branch_addr = 1'b0;
    checks++;
    if (mem_bus.imem_addr !== a) begin
      failures++;
      $display("FAIL goto_addr got=%h want=%h", mem_bus.imem_addr, a);
    end
  endtask

  task automatic test_reset();
    #1 nreset = 1'b0;
    #2;
    checks += 3;
    if (instruction_out !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", instruction_out); end
    if (return_addr_out !== 14'h0) begin failures++; $display("FAIL reset_ret got=%h want=0", return_addr_out); end
    if (mem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", mem_bus.imem_req); end
    tick();
    tick();
    checks++;
    if (mem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req_held got=%b want=0", mem_bus.imem_req); end
    nreset = 1'b1;
    tick();
    checks += 2;
    if (mem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b want=1", mem_bus.imem_req); end
    if (mem_bus.imem_addr !== RST_PC) begin failures++; $display("FAIL first_addr got=%h want=%h", mem_bus.imem_addr, RST_PC); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{instr: mem_word(14'(i)), ret: 14'(i + 1), chk_ret: 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      checks += 3;
      if (instruction_out !== e.instr) begin failures++; $display("FAIL zw_instr[%0d] got=%h want=%h", i, instruction_out, e.instr); end
      if (return_addr_out !== e.ret) begin failures++; $display("FAIL zw_ret[%0d] got=%h want=%h", i, return_addr_out, e.ret); end
      if (mem_bus.imem_addr !== 14'(i + 1)) begin failures++; $display("FAIL zw_addr[%0d] got=%h want=%h", i, mem_bus.imem_addr, i + 1); end
    end
  endtask

  task automatic test_wait_states();
    goto_pc(14'h005);
    wait_states = 2;
    exp_q.push_back('{instr: 32'h0, ret: 14'h0, chk_ret: 1'b0});
    exp_q.push_back('{instr: 32'h0, ret: 14'h0, chk_ret: 1'b0});
    exp_q.push_back('{instr: mem_word(14'h005), ret: 14'h006, chk_ret: 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (instruction_out !== e.instr) begin failures++; $display("FAIL ws_instr[%0d] got=%h want=%h", i, instruction_out, e.instr); end
      if (e.chk_ret) begin
        checks++;
        if (return_addr_out !== e.ret) begin failures++; $display("FAIL ws_ret[%0d] got=%h want=%h", i, return_addr_out, e.ret); end
      end
      if (i < 2) begin
        checks++;
        if (mem_bus.imem_addr !== 14'h005) begin failures++; $display("FAIL ws_addr[%0d] got=%h want=005", i, mem_bus.imem_addr); end
      end
    end
    wait_states = 0;
  endtask

  task automatic test_stall();
    goto_pc(14'h007);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{instr: mem_word(14'h007), ret: 14'h008, chk_ret: 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      checks += 4;
      if (instruction_out !== e.instr) begin failures++; $display("FAIL stall_instr[%0d] got=%h want=%h", i, instruction_out, e.instr); end
      if (return_addr_out !== e.ret) begin failures++; $display("FAIL stall_ret[%0d] got=%h want=%h", i, return_addr_out, e.ret); end
      if (mem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] got=%b want=0", i, mem_bus.imem_req); end
      if (dut.state_q !== HOLD) begin failures++; $display("FAIL stall_state[%0d] got=%0d want=%0d", i, dut.state_q, HOLD); end
    end
    stall = 1'b0;
    exp_q.push_back('{instr: mem_word(14'h008), ret: 14'h009, chk_ret: 1'b1});
    tick();
    e = exp_q.pop_front();
    checks += 4;
    if (instruction_out !== e.instr) begin failures++; $display("FAIL release_instr got=%h want=%h", instruction_out, e.instr); end
    if (return_addr_out !== e.ret) begin failures++; $display("FAIL release_ret got=%h want=%h", return_addr_out, e.ret); end
    if (mem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL release_req got=%b want=1", mem_bus.imem_req); end
    if (mem_bus.imem_addr !== 14'h009) begin failures++; $display("FAIL release_addr got=%h want=009", mem_bus.imem_addr); end
  endtask

  task automatic test_branch();
    logic [ADDR_W-1:0] exp_addr [6];
    exp_addr = '{14'h020, 14'h020, 14'h100, 14'h100, 14'h100, 14'h101};
    goto_pc(14'h020);
    wait_states = 2;
    exp_q.push_back('{instr: 32'h0, ret: 14'h0, chk_ret: 1'b1});
    for (int i = 1; i < 5; i++) exp_q.push_back('{instr: 32'h0, ret: 14'h0, chk_ret: 1'b0});
    exp_q.push_back('{instr: mem_word(14'h100), ret: 14'h101, chk_ret: 1'b1});
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        take_branch_addr = 1'b1;
        branch_addr = 14'h100;
      end
      tick();
      take_branch_addr = 1'b0;
      branch_addr = '0;
      e = exp_q.pop_front();
      checks += 2;
      if (instruction_out !== e.instr) begin failures++; $display("FAIL br_instr[%0d] got=%h want=%h", i, instruction_out, e.instr); end
      if (mem_bus.imem_addr !== exp_addr[i]) begin failures++; $display("FAIL br_addr[%0d] got=%h want=%h", i, mem_bus.imem_addr, exp_addr[i]); end
      if (e.chk_ret) begin
        checks++;
        if (return_addr_out !== e.ret) begin failures++; $display("FAIL br_ret[%0d] got=%h want=%h", i, return_addr_out, e.ret); end
      end
    end
    wait_states = 0;
  endtask

  task automatic test_wrap();
    goto_pc(14'h3FFF);
    exp_q.push_back('{instr: mem_word(14'h3FFF), ret: 14'h0000, chk_ret: 1'b1});
    tick();
    e = exp_q.pop_front();
    checks += 3;
    if (instruction_out !== e.instr) begin failures++; $display("FAIL wrap_instr got=%h want=%h", instruction_out, e.instr); end
    if (return_addr_out !== e.ret) begin failures++; $display("FAIL wrap_ret got=%h want=%h", return_addr_out, e.ret); end
    if (mem_bus.imem_addr !== 14'h0000) begin failures++; $display("FAIL wrap_addr got=%h want=0000", mem_bus.imem_addr); end
  endtask

  task automatic test_reset_mid();
    goto_pc(14'h03F);
    tick();
    wait_states = 3;
    checks++;
    if (mem_bus.imem_addr !== 14'h040) begin failures++; $display("FAIL mid_addr got=%h want=040", mem_bus.imem_addr); end
    #3 nreset = 1'b0;
    #1;
    checks += 3;
    if (instruction_out !== 32'h0) begin failures++; $display("FAIL mid_rst_instr got=%h want=0", instruction_out); end
    if (return_addr_out !== 14'h0) begin failures++; $display("FAIL mid_rst_ret got=%h want=0", return_addr_out); end
    if (mem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req got=%b want=0", mem_bus.imem_req); end
    tick();
    nreset = 1'b1;
    tick();
    checks += 2;
    if (mem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL mid_rel_req got=%b want=1", mem_bus.imem_req); end
    if (mem_bus.imem_addr !== RST_PC) begin failures++; $display("FAIL mid_rel_addr got=%h want=%h", mem_bus.imem_addr, RST_PC); end
    wait_states = 0;
    exp_q.push_back('{instr: mem_word(RST_PC), ret: RST_PC + 14'd1, chk_ret: 1'b1});
    tick();
    e = exp_q.pop_front();
    checks += 2;
    if (instruction_out !== e.instr) begin failures++; $display("FAIL mid_first_instr got=%h want=%h", instruction_out, e.instr); end
    if (return_addr_out !== e.ret) begin failures++; $display("FAIL mid_first_ret got=%h want=%h", return_addr_out, e.ret); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
